// File: rtl/iomem_xbar.sv
// PicoSoC iomem interconnect: decodes addr[31:24] onto NUM_SLAVES peripherals,
// watches each access with a timeout and serves a fault-status window itself.
module iomem_xbar #(
    parameter int          NUM_SLAVES     = 8,
    parameter logic [7:0]  BASE_BYTE      = 8'h03,
    parameter logic [7:0]  STATUS_BYTE    = 8'h0F,
    parameter int          TIMEOUT_CYCLES = 1024,
    parameter logic [31:0] TIMEOUT_RDATA  = 32'h0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    m_valid,
    output logic                    m_ready,
    input  logic [3:0]              m_wstrb,
    input  logic [31:0]             m_addr,
    input  logic [31:0]             m_wdata,
    output logic [31:0]             m_rdata,
    output logic [NUM_SLAVES-1:0]   s_valid,
    input  logic [NUM_SLAVES-1:0]   s_ready,
    input  logic [32*NUM_SLAVES-1:0] s_rdata,
    output logic [3:0]              s_wstrb,
    output logic [31:0]             s_addr,
    output logic [31:0]             s_wdata,
    output logic [1:0]              fsm_state
);
    // Handshake: a request is taken when m_valid is sampled high in IDLE; the
    // fields must stay put until the single-cycle m_ready pulse. Slaves see
    // s_valid held until s_ready (from the selected slave only) or timeout.
    typedef enum logic [1:0] {IDLE = 2'd0, ACTIVE = 2'd1, RESP = 2'd2} state_t;

    state_t                state;
    logic [15:0]           timeout_count;
    logic [15:0]           unmapped_count;
    logic [31:0]           last_fault_addr;
    logic [31:0]           tcnt;
    logic [7:0]            idx;
    logic [NUM_SLAVES-1:0] dec;
    logic                  slave_hit;
    logic                  status_hit;
    logic                  sel_ready;
    logic                  timed_out;
    logic [31:0]           sel_rdata;
    logic [31:0]           status_word;

    assign fsm_state = state;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_comb begin
        idx = m_addr[31:24] - BASE_BYTE;
        dec = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            dec[i] = (idx == 8'(i));
        end
        slave_hit  = |dec;
        status_hit = (m_addr[31:24] == STATUS_BYTE);
        // s_valid is the latched one-hot slave index, so it doubles as the mux select.
        sel_ready  = |(s_ready & s_valid);
        sel_rdata  = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (s_valid[i]) sel_rdata = s_rdata[32*i +: 32];
        end
        timed_out = (TIMEOUT_CYCLES != 0) && (tcnt == 32'(TIMEOUT_CYCLES - 1));
        case (m_addr[3:2])
            2'd0:    status_word = {16'b0, timeout_count};
            2'd1:    status_word = last_fault_addr;
            2'd2:    status_word = {16'b0, unmapped_count};
            default: status_word = 32'(NUM_SLAVES);
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            m_ready         <= 1'b0;
            m_rdata         <= '0;
            s_valid         <= '0;
            s_addr          <= '0;
            s_wdata         <= '0;
            s_wstrb         <= '0;
            timeout_count   <= '0;
            unmapped_count  <= '0;
            last_fault_addr <= '0;
            tcnt            <= '0;
        end else begin
            m_ready <= 1'b0;
            case (state)
                IDLE: begin
                    if (m_valid) begin
                        s_addr  <= m_addr;
                        s_wdata <= m_wdata;
                        s_wstrb <= m_wstrb;
                        tcnt    <= '0;
                        if (slave_hit) begin
                            s_valid <= dec;
                            state   <= ACTIVE;
                        end else if (status_hit) begin
                            if (m_wstrb != 4'b0) begin
                                timeout_count   <= '0;
                                unmapped_count  <= '0;
                                last_fault_addr <= '0;
                                m_rdata         <= '0;
                            end else begin
                                m_rdata <= status_word;
                            end
                            m_ready <= 1'b1;
                            state   <= RESP;
                        end else begin
                            m_rdata        <= TIMEOUT_RDATA;
                            unmapped_count <= sat_inc(unmapped_count);
                            m_ready        <= 1'b1;
                            state          <= RESP;
                        end
                    end
                end
                ACTIVE: begin
                    tcnt <= tcnt + 32'd1;
                    // A ready in the last allowed cycle beats the timeout.
                    if (sel_ready) begin
                        m_rdata <= sel_rdata;
                        s_valid <= '0;
                        m_ready <= 1'b1;
                        state   <= RESP;
                    end else if (timed_out) begin
                        m_rdata         <= TIMEOUT_RDATA;
                        timeout_count   <= sat_inc(timeout_count);
                        last_fault_addr <= s_addr;
                        s_valid         <= '0;
                        m_ready         <= 1'b1;
                        state           <= RESP;
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_iomem_xbar.sv
// Directed bench for iomem_xbar: a scripted master plus per-transaction slave
// responder; expected data/latency queued at drive time and checked at m_ready.
module tb_iomem_xbar;
  localparam int NS = 8;
  localparam logic [31:0] TO_DATA = 32'hDEAD_BEEF;

  logic            clk = 1'b0;
  logic            reset;
  logic            m_valid;
  logic            m_ready;
  logic [3:0]      m_wstrb;
  logic [31:0]     m_addr;
  logic [31:0]     m_wdata;
  logic [31:0]     m_rdata;
  logic [NS-1:0]   s_valid;
  logic [NS-1:0]   s_ready;
  logic [32*NS-1:0] s_rdata;
  logic [3:0]      s_wstrb;
  logic [31:0]     s_addr;
  logic [31:0]     s_wdata;
  logic [1:0]      fsm_state;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];
  int          lat_q[$];
  int          vcnt_q[$];

  iomem_xbar #(
    .NUM_SLAVES(NS), .BASE_BYTE(8'h03), .STATUS_BYTE(8'h0F),
    .TIMEOUT_CYCLES(16), .TIMEOUT_RDATA(TO_DATA)
  ) dut (
    .clk(clk), .reset(reset), .m_valid(m_valid), .m_ready(m_ready),
    .m_wstrb(m_wstrb), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata),
    .s_valid(s_valid), .s_ready(s_ready), .s_rdata(s_rdata),
    .s_wstrb(s_wstrb), .s_addr(s_addr), .s_wdata(s_wdata), .fsm_state(fsm_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic init_rdata();
    for (int i = 0; i < NS; i++) s_rdata[32*i +: 32] = 32'hEE00_0000 | 32'(i);
  endtask

  // slave < 0: no slave involved; delay < 0: selected slave never answers.
  task automatic txn(input string tag, input logic [31:0] addr, input logic [3:0] wstrb,
                     input logic [31:0] wdata, input int slave, input int delay,
                     input logic [31:0] sdata, input bit drop,
                     input logic [31:0] exp_data, input int exp_lat, input int exp_vcnt);
    int cyc;
    int vcnt;
    bit done;
    bit stray;
    bit unstable;
    logic [NS-1:0] mask;
    logic [31:0] got;
    mask = '0;
    got = '0;
    init_rdata();
    if (slave >= 0) begin
      mask[slave] = 1'b1;
      s_rdata[32*slave +: 32] = sdata;
    end
    exp_q.push_back(exp_data);
    lat_q.push_back(exp_lat);
    vcnt_q.push_back(exp_vcnt);
    @(negedge clk);
    m_valid = 1'b1; m_addr = addr; m_wstrb = wstrb; m_wdata = wdata;
    cyc = 0; vcnt = 0; done = 0; stray = 0; unstable = 0;
    while (!done && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (drop && cyc == 2) m_valid = 1'b0;
      if ((s_valid & ~mask) != '0) stray = 1;
      if (s_valid != '0 && (s_addr !== addr || s_wdata !== wdata || s_wstrb !== wstrb)) unstable = 1;
      if ((s_valid & mask) != '0) vcnt++;
      s_ready = '0;
      if (m_ready) begin
        done = 1;
        got = m_rdata;
        m_valid = 1'b0;
      end else if (slave >= 0 && delay >= 0 && (s_valid & mask) != '0 && vcnt == delay + 1) begin
        s_ready = mask;
      end
    end
    m_valid = 1'b0;
    s_ready = '0;
    chk($sformatf("%s_latency", tag), done ? 32'(cyc) : 32'hFFFF_FFFF, 32'(lat_q.pop_front()));
    chk($sformatf("%s_rdata", tag), got, exp_q.pop_front());
    chk($sformatf("%s_valid_cycles", tag), 32'(vcnt), 32'(vcnt_q.pop_front()));
    chk($sformatf("%s_no_stray_valid", tag), {31'b0, stray}, 32'd0);
    chk($sformatf("%s_req_stable", tag), {31'b0, unstable}, 32'd0);
  endtask

  task automatic status_rd(input string tag, input int word, input logic [31:0] exp);
    txn(tag, 32'h0F00_0000 | 32'(word << 2), 4'h0, 32'h0, -1, -1, 32'h0, 1'b0, exp, 1, 0);
  endtask

  initial begin
    bit seen;
    reset = 1'b1; m_valid = 1'b0; m_wstrb = '0; m_addr = '0; m_wdata = '0; s_ready = '0;
    init_rdata();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("rst_m_ready", {31'b0, m_ready}, 32'd0);
    chk("rst_m_rdata", m_rdata, 32'd0);
    chk("rst_s_valid", 32'(s_valid), 32'd0);
    chk("rst_s_addr", s_addr, 32'd0);
    chk("rst_s_wdata", s_wdata, 32'd0);
    chk("rst_s_wstrb", 32'(s_wstrb), 32'd0);
    chk("rst_state", 32'(fsm_state), 32'd0);
    status_rd("rst_word0", 0, 32'd0);

    txn("rd_s2", 32'h0500_0004, 4'h0, 32'h0, 2, 0, 32'h1234_5678, 1'b0, 32'h1234_5678, 2, 1);
    txn("wr_s0", 32'h0300_0000, 4'hF, 32'hA5A5_A5A5, 0, 5, 32'h1111_0000, 1'b0, 32'h1111_0000, 7, 6);
    txn("s7_drop", 32'h0A00_0008, 4'h3, 32'h0000_BEEF, 7, 2, 32'h7777_7777, 1'b1, 32'h7777_7777, 4, 3);

    txn("timeout_s4", 32'h0700_0000, 4'h0, 32'h0, 4, -1, 32'h4444_4444, 1'b0, TO_DATA, 17, 16);
    status_rd("to_word0", 0, 32'd1);
    status_rd("to_word1", 1, 32'h0700_0000);
    txn("late_ready_s3", 32'h0600_0000, 4'h0, 32'h0, 3, 15, 32'hCAFE_0001, 1'b0, 32'hCAFE_0001, 17, 16);
    status_rd("late_word0", 0, 32'd1);

    txn("unmap_20", 32'h2000_0000, 4'h0, 32'h0, -1, -1, 32'h0, 1'b0, TO_DATA, 1, 0);
    txn("unmap_01", 32'h0100_0000, 4'h0, 32'h0, -1, -1, 32'h0, 1'b0, TO_DATA, 1, 0);
    txn("unmap_0b", 32'h0B00_0000, 4'hF, 32'h1, -1, -1, 32'h0, 1'b0, TO_DATA, 1, 0);
    status_rd("um_word2", 2, 32'd3);
    status_rd("num_slaves", 3, 32'd8);
    txn("status_clear", 32'h0F00_0000, 4'hF, 32'hFFFF_FFFF, -1, -1, 32'h0, 1'b0, 32'h0, 1, 0);
    status_rd("clr_word0", 0, 32'd0);
    status_rd("clr_word1", 1, 32'd0);
    status_rd("clr_word2", 2, 32'd0);

    txn("pre_rst_unmap", 32'h3000_0000, 4'h0, 32'h0, -1, -1, 32'h0, 1'b0, TO_DATA, 1, 0);
    @(negedge clk);
    m_valid = 1'b1; m_addr = 32'h0800_0000; m_wstrb = 4'h0; m_wdata = 32'h0;
    repeat (3) @(negedge clk);
    chk("stall_s5_valid", 32'(s_valid), 32'h0000_0020);
    reset = 1'b1;
    m_valid = 1'b0;
    @(negedge clk);
    chk("midrst_s_valid", 32'(s_valid), 32'd0);
    chk("midrst_m_ready", {31'b0, m_ready}, 32'd0);
    chk("midrst_state", 32'(fsm_state), 32'd0);
    chk("midrst_s_addr", s_addr, 32'd0);
    reset = 1'b0;
    seen = 0;
    repeat (5) begin
      @(negedge clk);
      if (m_ready) seen = 1;
    end
    chk("midrst_no_resp", {31'b0, seen}, 32'd0);
    status_rd("midrst_word2", 2, 32'd0);
    txn("fresh_s1", 32'h0400_0010, 4'h0, 32'h0, 1, 1, 32'h55AA_55AA, 1'b0, 32'h55AA_55AA, 3, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
